// File: rtl/lock_actuator_ctrl.sv
// lock_actuator_ctrl: turns code verdicts into a timed unlock pulse, with consecutive-failure lockout.
// Optional sticky tamper alarm when LOCK_ALARM_EN is defined; otherwise alarm is tied low.
module lock_actuator_ctrl #(
    parameter int UNLOCK_CYCLES  = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16,
    localparam int FCW = $clog2(MAX_FAIL + 1)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_val,
    input  logic           in_data,
    output logic           unlock,
    output logic           locked_out,
    output logic           ready,
    output logic [FCW-1:0] fail_cnt,
    output logic           alarm
);
    localparam int MAXC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {LOCKED, OPEN, LOCKOUT} state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [FCW-1:0] fail_q, fail_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LOCKED;
            timer_q <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        case (state_q)
            LOCKED: begin
                if (in_val && in_data) begin
                    state_d = OPEN;
                    timer_d = TW'(UNLOCK_CYCLES - 1);
                    fail_d  = '0;
                end else if (in_val && fail_q == FCW'(MAX_FAIL - 1)) begin
                    state_d = LOCKOUT;
                    timer_d = TW'(LOCKOUT_CYCLES - 1);
                    fail_d  = FCW'(MAX_FAIL);
                end else if (in_val) begin
                    fail_d = fail_q + FCW'(1);
                end
            end
            OPEN, LOCKOUT: begin
                // verdicts arriving here are dropped, never queued
                if (timer_q == '0) begin
                    state_d = LOCKED;
                    fail_d  = (state_q == LOCKOUT) ? '0 : fail_q;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_comb begin
        unlock     = state_q == OPEN;
        locked_out = state_q == LOCKOUT;
        ready      = state_q == LOCKED;
        fail_cnt   = fail_q;
    end

`ifdef LOCK_ALARM_EN
    logic alarm_q, alarm_d;

    always_comb begin
        alarm_d = (state_d == OPEN && state_q != OPEN) ? 1'b0 :
                  (state_d == LOCKOUT && state_q != LOCKOUT) ? 1'b1 : alarm_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) alarm_q <= 1'b0;
        else       alarm_q <= alarm_d;
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif
endmodule
